// File: rtl/pic_int_sequencer_if.sv
// Signal bundle between the 8259 interrupt sequencer core and its surroundings
// (request lines, INTA strobe, configuration, vector and status outputs).
interface pic_int_sequencer_if;
  logic [7:0] IR;
  logic       INTA_n;
  logic       INIT;
  logic       LTIM;
  logic       AEOI;
  logic [7:0] IMR;
  logic [4:0] VEC_BASE;
  logic       OCW2_WR;
  logic [7:0] OCW2_DATA;
  logic       INT;
  logic [7:0] VEC_DATA;
  logic       VEC_OE;
  logic [7:0] IRR_Q;
  logic [7:0] ISR_Q;

  modport master (
    output IR, INTA_n, INIT, LTIM, AEOI, IMR, VEC_BASE, OCW2_WR, OCW2_DATA,
    input  INT, VEC_DATA, VEC_OE, IRR_Q, ISR_Q
  );

  modport slave (
    input  IR, INTA_n, INIT, LTIM, AEOI, IMR, VEC_BASE, OCW2_WR, OCW2_DATA,
    output INT, VEC_DATA, VEC_OE, IRR_Q, ISR_Q
  );
endinterface

// File: rtl/pic_int_sequencer.sv
// 8259 interrupt controller core: IRR/ISR, rotating priority resolution,
// INT generation and the two-pulse INTA vector handshake with OCW2 commands.
module pic_int_sequencer #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned SPURIOUS_LEVEL = 7
) (
    input logic                  CLK,
    input logic                  RESET,
    pic_int_sequencer_if.slave   bus
);

    typedef enum logic [2:0] {IDLE, PEND, ACK1, WAIT2, VEC} state_t;

    // Returns {found, level} of the best-ranked set bit, scanning from lowest+1.
    function automatic logic [3:0] pick(input logic [7:0] v, input logic [2:0] low);
        logic [3:0] r;
        logic [2:0] i;
        r = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            i = low + 3'd1 + 3'(k);
            if (!r[3] && v[i]) r = {1'b1, i};
        end
        return r;
    endfunction

    logic [7:0] ir_sync   [SYNC_STAGES];
    logic       inta_sync [SYNC_STAGES];
    logic [7:0] ir_s, ir_prev;
    logic       inta_s, inta_prev, inta_fall, inta_rise;

    state_t     state_q, state_d;
    logic [7:0] irr_q, irr_d, isr_q, isr_d, isr_o, req, irr_clr;
    logic [2:0] lowest_q, low_o, lvl_q, lvl_d;
    logic       spur_q, spur_d;
    logic [7:0] vec_q, vec_d;
    logic [3:0] h_now, cand, hisr;
    logic       int_cond, ack_set, aeoi_clr;
    logic [2:0] ocw_l;
    logic       unused_ocw2_bits;

    assign unused_ocw2_bits = ^bus.OCW2_DATA[4:3];

    always_ff @(posedge CLK) begin
        ir_sync[0]   <= bus.IR;
        inta_sync[0] <= bus.INTA_n;
        for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
            ir_sync[s]   <= ir_sync[s-1];
            inta_sync[s] <= inta_sync[s-1];
        end
        ir_prev   <= ir_s;
        inta_prev <= inta_s;
    end

    assign ir_s      = ir_sync[SYNC_STAGES-1];
    assign inta_s    = inta_sync[SYNC_STAGES-1];
    assign inta_fall = inta_prev & ~inta_s;
    assign inta_rise = ~inta_prev & inta_s;

    // OCW2 takes effect before resolution so an INTA in the same cycle sees it.
    always_comb begin
        isr_o = isr_q;
        low_o = lowest_q;
        ocw_l = bus.OCW2_DATA[2:0];
        h_now = pick(isr_q, lowest_q);
        if (bus.OCW2_WR) begin
            unique case (bus.OCW2_DATA[7:5])
                3'b001: if (h_now[3]) isr_o[h_now[2:0]] = 1'b0;
                3'b011: isr_o[ocw_l] = 1'b0;
                3'b101: if (h_now[3]) begin
                    isr_o[h_now[2:0]] = 1'b0;
                    low_o = h_now[2:0];
                end
                3'b111: begin
                    isr_o[ocw_l] = 1'b0;
                    low_o = ocw_l;
                end
                3'b110: low_o = ocw_l;
                default: ;
            endcase
        end
    end

    always_comb begin
        req      = irr_q & ~bus.IMR;
        cand     = pick(req, low_o);
        hisr     = pick(isr_o, low_o);
        int_cond = cand[3] && (!hisr[3] ||
                   ((cand[2:0] - low_o - 3'd1) < (hisr[2:0] - low_o - 3'd1)));
    end

    always_comb begin
        state_d  = state_q;
        lvl_d    = lvl_q;
        spur_d   = spur_q;
        vec_d    = vec_q;
        ack_set  = 1'b0;
        aeoi_clr = 1'b0;
        unique case (state_q)
            IDLE:  if (int_cond) state_d = PEND;
            PEND:  if (inta_fall) begin
                state_d = ACK1;
                lvl_d   = cand[3] ? cand[2:0] : 3'(SPURIOUS_LEVEL);
                spur_d  = !cand[3];
                ack_set = cand[3];
            end
            ACK1:  if (inta_rise) state_d = WAIT2;
            WAIT2: if (inta_fall) begin
                state_d = VEC;
                vec_d   = {bus.VEC_BASE, lvl_q};
            end
            VEC:   if (inta_rise) begin
                state_d  = IDLE;
                aeoi_clr = bus.AEOI && !spur_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        isr_d   = isr_o;
        irr_clr = '0;
        if (ack_set) begin
            isr_d[cand[2:0]]   = 1'b1;
            irr_clr[cand[2:0]] = 1'b1;
        end
        if (aeoi_clr) isr_d[lvl_q] = 1'b0;
        // A fresh edge on the bit being acknowledged re-arms it.
        irr_d = bus.LTIM ? ir_s : ((irr_q & ~irr_clr) | (ir_s & ~ir_prev));
    end

    always_ff @(posedge CLK) begin
        if (RESET || bus.INIT) begin
            state_q  <= IDLE;
            irr_q    <= '0;
            isr_q    <= '0;
            lowest_q <= 3'd7;
            lvl_q    <= '0;
            spur_q   <= 1'b0;
            vec_q    <= '0;
        end else begin
            state_q  <= state_d;
            irr_q    <= irr_d;
            isr_q    <= isr_d;
            lowest_q <= low_o;
            lvl_q    <= lvl_d;
            spur_q   <= spur_d;
            vec_q    <= vec_d;
        end
    end

    assign bus.INT      = (state_q == PEND);
    assign bus.VEC_OE   = (state_q == VEC);
    assign bus.VEC_DATA = vec_q;
    assign bus.IRR_Q    = irr_q;
    assign bus.ISR_Q    = isr_q;

endmodule

// File: tb/tb_pic_int_sequencer.sv
// Directed bench for pic_int_sequencer: vectors are checked by a scoreboard
// monitor, status registers and INT by inline comparisons.
module tb_pic_int_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;
    logic [7:0] exp_q [$];
    logic oe_d = 1'b0;

    pic_int_sequencer_if bus ();

    pic_int_sequencer #(.SYNC_STAGES(2), .SPURIOUS_LEVEL(7)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Vector monitor: every VEC_OE assertion must match the oldest expectation.
    always @(negedge clk) begin
        if (bus.VEC_OE && !oe_d) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL vector: got %h with no vector expected", bus.VEC_DATA);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (bus.VEC_DATA !== e) begin
                    n_fail++;
                    $display("FAIL vector: got %h expected %h", bus.VEC_DATA, e);
                end
            end
        end
        oe_d = bus.VEC_OE;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pulse_ir(input logic [7:0] m);
        bus.IR = m;
        tick(3);
        bus.IR = '0;
        tick(6);
    endtask

    task automatic inta_half(input logic v);
        bus.INTA_n = v;
        tick(4);
    endtask

    task automatic inta_ack();
        inta_half(1'b0);
        inta_half(1'b1);
        inta_half(1'b0);
        inta_half(1'b1);
    endtask

    task automatic ocw2(input logic [7:0] d);
        bus.OCW2_DATA = d;
        bus.OCW2_WR   = 1'b1;
        tick(1);
        bus.OCW2_WR   = 1'b0;
        tick(3);
    endtask

    initial begin
        bus.IR = '0; bus.INTA_n = 1'b1; bus.INIT = 1'b0; bus.LTIM = 1'b0;
        bus.AEOI = 1'b0; bus.IMR = '0; bus.VEC_BASE = 5'h08;
        bus.OCW2_WR = 1'b0; bus.OCW2_DATA = '0;
        tick(4);
        check("rst_int", {7'd0, bus.INT}, 8'h00);
        check("rst_oe", {7'd0, bus.VEC_OE}, 8'h00);
        check("rst_vec", bus.VEC_DATA, 8'h00);
        check("rst_irr", bus.IRR_Q, 8'h00);
        check("rst_isr", bus.ISR_Q, 8'h00);
        rst = 1'b0;
        tick(2);

        // 1: single request IR3
        pulse_ir(8'h08);
        check("t1_int", {7'd0, bus.INT}, 8'h01);
        check("t1_irr", bus.IRR_Q, 8'h08);
        exp_q.push_back(8'h43);
        inta_ack();
        check("t1_isr", bus.ISR_Q, 8'h08);
        check("t1_irr_clr", bus.IRR_Q, 8'h00);
        check("t1_int_low", {7'd0, bus.INT}, 8'h00);

        // 2: IR2 and IR5 together, nested by NS-EOI
        ocw2(8'h20);
        check("t2_isr0", bus.ISR_Q, 8'h00);
        pulse_ir(8'h24);
        exp_q.push_back(8'h42);
        inta_ack();
        check("t2_isr2", bus.ISR_Q, 8'h04);
        check("t2_int_blk", {7'd0, bus.INT}, 8'h00);
        ocw2(8'h20);
        tick(2);
        check("t2_int_re", {7'd0, bus.INT}, 8'h01);
        exp_q.push_back(8'h45);
        inta_ack();
        check("t2_isr5", bus.ISR_Q, 8'h20);

        // 3: lower priority blocked, higher nests
        pulse_ir(8'h40);
        check("t3_irr6", bus.IRR_Q, 8'h40);
        check("t3_int_blk", {7'd0, bus.INT}, 8'h00);
        pulse_ir(8'h02);
        check("t3_int", {7'd0, bus.INT}, 8'h01);
        exp_q.push_back(8'h41);
        inta_ack();
        check("t3_isr", bus.ISR_Q, 8'h22);
        ocw2(8'h20);
        check("t3_isr_ns1", bus.ISR_Q, 8'h20);
        ocw2(8'h20);
        tick(2);
        exp_q.push_back(8'h46);
        inta_ack();
        check("t3_isr6", bus.ISR_Q, 8'h40);
        ocw2(8'h20);
        check("t3_clean", bus.ISR_Q, 8'h00);

        // 4: rotate on specific EOI L=4
        pulse_ir(8'h10);
        exp_q.push_back(8'h44);
        inta_ack();
        check("t4_isr4", bus.ISR_Q, 8'h10);
        ocw2(8'hE4);
        check("t4_isr_rot", bus.ISR_Q, 8'h00);
        pulse_ir(8'h21);
        exp_q.push_back(8'h45);
        inta_ack();
        check("t4_isr5", bus.ISR_Q, 8'h20);
        check("t4_irr0", bus.IRR_Q, 8'h01);
        check("t4_int_blk", {7'd0, bus.INT}, 8'h00);
        ocw2(8'h20);
        tick(2);
        exp_q.push_back(8'h40);
        inta_ack();
        check("t4_isr0", bus.ISR_Q, 8'h01);
        ocw2(8'hC7);
        ocw2(8'h20);
        check("t4_clean", bus.ISR_Q, 8'h00);

        // 5: level mode request withdrawn before INTA -> spurious
        bus.LTIM = 1'b1;
        tick(2);
        bus.IR = 8'h10;
        tick(5);
        check("t5_int", {7'd0, bus.INT}, 8'h01);
        bus.IR = 8'h00;
        tick(5);
        check("t5_irr_gone", bus.IRR_Q, 8'h00);
        check("t5_int_held", {7'd0, bus.INT}, 8'h01);
        exp_q.push_back(8'h47);
        inta_ack();
        check("t5_isr", bus.ISR_Q, 8'h00);
        check("t5_int_low", {7'd0, bus.INT}, 8'h00);
        bus.LTIM = 1'b0;
        tick(2);

        // 6: AEOI, then reset between INTA pulses
        bus.AEOI = 1'b1;
        pulse_ir(8'h40);
        exp_q.push_back(8'h46);
        inta_half(1'b0);
        inta_half(1'b1);
        check("t6_isr_set", bus.ISR_Q, 8'h40);
        inta_half(1'b0);
        check("t6_oe", {7'd0, bus.VEC_OE}, 8'h01);
        check("t6_isr_hold", bus.ISR_Q, 8'h40);
        inta_half(1'b1);
        check("t6_isr_aeoi", bus.ISR_Q, 8'h00);
        check("t6_oe_low", {7'd0, bus.VEC_OE}, 8'h00);
        pulse_ir(8'h40);
        inta_half(1'b0);
        inta_half(1'b1);
        check("t6_isr_mid", bus.ISR_Q, 8'h40);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        check("t6_rst_isr", bus.ISR_Q, 8'h00);
        check("t6_rst_int", {7'd0, bus.INT}, 8'h00);
        inta_half(1'b0);
        check("t6_rst_oe", {7'd0, bus.VEC_OE}, 8'h00);
        inta_half(1'b1);
        check("t6_isr_end", bus.ISR_Q, 8'h00);

        tick(4);
        check("sb_drained", 8'(exp_q.size()), 8'h00);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
